pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- XLEN, 32, PC width in bits.
- INC_BYTES, 4, sequential increment; legal values 2 or 4.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on trap.
- CNT_W, 16, width of the fetch counter.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- stall, input, 1, pipeline hold request.
- fetch_ready, input, 1, fetch stage accepts the current PC.
- redirect_valid, input, 1, branch/jump redirect request.
- redirect_target, input, XLEN, redirect destination.
- trap, input, 1, trap request.
- pc, output, XLEN, registered current PC.
- pc_next_seq, output, XLEN, combinational pc + INC_BYTES.
- pc_valid, output, 1, pc is offered to fetch.
- misaligned, output, 1, fault flag.
- fetch_count, output, CNT_W, number of accepted fetches.

Function
REQ-003 pc_gen SHALL implement three states:
- IDLE: entered on reset.
- RUN
- FAULT

REQ-004 IDLE SHALL drive pc_valid=0 and SHALL transition to RUN on the next clock edge unconditionally.

REQ-005 In RUN, pc_valid SHALL be 1.

REQ-006 In IDLE and FAULT, pc_valid SHALL be 0.

REQ-007 A fetch is "accepted" in a cycle when pc_valid & fetch_ready & ~stall.

REQ-008 Next-PC priority SHALL be, highest first:
- rst
- trap
- redirect_valid
- accepted fetch
- hold

REQ-009 On an accepted fetch with no trap and no redirect, pc SHALL become pc + INC_BYTES modulo 2^XLEN, so pc=32'hFFFF_FFFC with INC_BYTES=4 wraps to 32'h0000_0000 with no flag.

REQ-010 When no fetch is accepted (stall=1 or fetch_ready=0) and there is no redirect or trap, pc SHALL hold its value.

REQ-011 Latency SHALL be one cycle: a redirect or trap sampled at edge N is visible on pc after edge N.

REQ-012 A redirect SHALL be taken in RUN regardless of stall and fetch_ready, and the concurrent fetch SHALL NOT be counted.

REQ-013 A redirect target is misaligned when:
- target[1:0] != 0 for INC_BYTES=4, or
- target[0] != 0 for INC_BYTES=2.

REQ-014 A misaligned redirect SHALL NOT load pc; pc SHALL hold, the state SHALL become FAULT, and misaligned SHALL be set to 1.

REQ-015 misaligned SHALL remain 1 until a trap or rst.

REQ-016 In FAULT:
- redirect_valid and fetch_ready SHALL be ignored.
- Only trap or rst SHALL leave FAULT.

REQ-017 A trap in any state SHALL:
- load pc=TRAP_PC,
- clear misaligned,
- enter RUN,
- not count a fetch in that cycle.

REQ-018 trap and redirect_valid asserted together SHALL resolve as a trap; the redirect is dropped and its alignment is not checked.

REQ-019 redirect_valid in IDLE SHALL be ignored.

REQ-020 fetch_count SHALL increment by 1 on each accepted fetch, wrapping from 2^CNT_W-1 to 0.

REQ-021 fetch_count SHALL NOT be cleared by trap or redirect.

REQ-022 pc_next_seq SHALL equal (pc + INC_BYTES) mod 2^XLEN combinationally in every state.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL load:
- pc=RESET_PC
- pc_valid=0
- misaligned=0
- fetch_count=0
- state=IDLE

REQ-024 rst SHALL override trap, redirect_valid and stall in the same cycle.

REQ-025 Reset asserted mid-operation, including in FAULT, SHALL abandon all state with no residual effect.

REQ-026 No output SHALL change asynchronously with rst.

Verification
REQ-027 The bench SHALL cover reset then free-run:
- Stimulus: rst for 2 cycles, fetch_ready=1, stall=0.
- Required response: pc_valid=0 in the first cycle, then pc = 0, 4, 8, 12 on successive cycles, with fetch_count=1, 2, 3.

REQ-028 The bench SHALL cover stall:
- Stimulus: at pc=32'h10, hold stall=1 for 3 cycles.
- Required response: pc holds 32'h10 and fetch_count is unchanged; after release pc=32'h14.

REQ-029 The bench SHALL cover redirect under stall:
- Stimulus: redirect_valid=1, redirect_target=32'h0000_0400, stall=1.
- Required response: pc=32'h400 on the next cycle and fetch_count is unchanged.

REQ-030 The bench SHALL cover a misaligned redirect and recovery:
- Stimulus: redirect_target=32'h0000_0402.
- Required response: pc holds, misaligned=1, pc_valid=0; a later redirect is ignored; trap then gives pc=32'h100, misaligned=0, pc_valid=1.

REQ-031 The bench SHALL cover wrap-around:
- Stimulus: redirect to 32'hFFFF_FFFC, then one accepted fetch.
- Required response: pc=32'h0000_0000, pc_next_seq=32'h4.

REQ-032 The bench SHALL cover simultaneous events:
- Stimulus 1: trap and redirect in the same cycle. Required response: pc=TRAP_PC.
- Stimulus 2: rst with trap. Required response: pc=RESET_PC, state IDLE.
- Stimulus 3: INC_BYTES=2 build, redirect to 32'h6. Required response: accepted, no fault.

Source files
------------

// File: rtl/pc_gen.sv
// ============================================================================
// pc_gen : program counter generator with redirect, trap and alignment fault
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int                XLEN      = 32,
  parameter int                INC_BYTES = 4,
  parameter logic [XLEN-1:0]   RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_PC   = 32'h0000_0100,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_next_seq,
  output logic             pc_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  INC_VAL    = XLEN'(INC_BYTES);
  localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'(INC_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              misaligned_q, misaligned_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic              accept;
  logic              target_bad;
  logic [XLEN-1:0]   pc_inc;

  assign pc_inc     = pc_q + INC_VAL;
  assign target_bad = |(redirect_target & ALIGN_MASK);
  // pc_valid is only ever high in RUN, so accept implies RUN.
  assign accept     = pc_valid_q & fetch_ready & ~stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;

    if (trap) begin
      // Trap wins over redirect; the dropped redirect is not alignment-checked.
      pc_d         = TRAP_PC;
      misaligned_d = 1'b0;
      state_d      = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (redirect_valid) begin
            if (target_bad) begin
              state_d      = ST_FAULT;
              misaligned_d = 1'b1;
            end else begin
              pc_d = redirect_target;
            end
          end else if (accept) begin
            pc_d          = pc_inc;
            fetch_count_d = fetch_count_q + CNT_ONE;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end

    pc_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pc_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign pc_next_seq = pc_inc;
  assign pc_valid    = pc_valid_q;
  assign misaligned  = misaligned_q;
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire
